regfile_window_writer: RTL and testbench
========================================

// Module: regfile_window_writer
// PURPOSE
//  Write side of the SPARC V8 windowed register file. It accepts register writebacks (logical
//  r0-r31 plus CWP) over a valid/ready handshake and buffers them in a 2-entry FIFO. It decodes
//  each entry to a one-hot physical enable and commits it to the physical register bank.
//  The whole bank is presented flattened to the 32x1 read-mux tree on the read side.
// PARAMETERS
//  NWINDOWS  4   register windows; legal values 2, 4, 8; CWPW = log2(NWINDOWS)
//  WIDTH     32  register data width
//  NPHYS     8+16*NWINDOWS (derived localparam, 72 at default): physical register count
// PORTS
//  clk        in   1            rising-edge clock
//  rst        in   1            synchronous, active-high reset
//  wr_valid   in   1            write request present
//  wr_ready   out  1            buffer can accept; transfer on wr_valid & wr_ready at posedge
//  wr_addr    in   5            logical register r0-r31
//  wr_cwp     in   CWPW         current window pointer for this write
//  wr_data    in   WIDTH        data to write
//  busy       out  1            buffer non-empty (a write is not yet visible)
//  commit_en  out  NPHYS        one-hot physical enable of the entry committing this cycle
//  regs_flat  out  NPHYS*WIDTH  physical bank, reg p at [p*WIDTH +: WIDTH]
// BEHAVIOUR
//  Reset (rst=1 at posedge): all regs_flat = 0, FIFO empty, wr_ready=0 while rst high,
//   busy=0, commit_en=0. wr_ready=1 in the first cycle after rst deasserts.
//  Mapping: r0-r7 -> p = r (globals).
//   r8-r31 -> p = 8 + ((cwp*16 + (r-8)) mod (16*NWINDOWS)).
//   This makes the ins of window w alias the outs of window w+1; the top window wraps to window 0.
//  r0: transfer is accepted and consumes a slot; commit_en stays 0 and bank p0 stays 0 always.
//  FIFO: depth 2. wr_ready = !full (registered count, no combinational path from wr_valid).
//  Commit: each cycle the FIFO is non-empty, the head is written to the bank at the posedge.
//   Head is popped the same edge. commit_en is combinational from the head (0 when empty).
//  Latency: accepted at edge N, visible in regs_flat after edge N+1. Back-to-back throughput
//   is 1 write/cycle, so the FIFO never exceeds 1 entry unless ...
//   Note: commit always drains, so full is reachable only as push+no-pop; under the rules
//   above the count stays <=1. The 2nd slot is kept for a future stall input.
//  Simultaneous push and pop: count unchanged; order is preserved (FIFO, oldest commits first).
//  Same physical reg written by consecutive entries: later write wins, in commit order.
//   Aliased writes (e.g. r24 at cwp=0 then r8 at cwp=1) hit the same p.
//  wr_cwp is sampled with the transfer; later cwp changes do not affect buffered entries.
//  wr_valid while !wr_ready: no transfer; the producer must hold addr/cwp/data stable.
//  rst mid-operation: buffered entries are discarded (never committed); the bank is cleared.
// STRUCTURE
//  Shared package (sparc_rf_pkg): NWINDOWS default, REG_GLOBALS=8, REGS_PER_WIN=16,
//   the phys_index function (addr, cwp -> p), and the wr_entry struct {addr, cwp, data}.
//  One sub-module: rf_phys_decoder (combinational addr+cwp -> p and one-hot NPHYS enable).
//   It is the demux counterpart of the read mux tree. FIFO and bank stay inline.
// TESTING
//  Reset: drive rst 2 cycles -> regs_flat==0, wr_ready==0 during rst, ==1 the cycle after; busy==0.
//  Single write r5=0xDEADBEEF cwp=2 -> commit_en bit5 one cycle later; p5==DEADBEEF after edge N+1.
//  Alias: r24=0x11111111 @cwp0 -> p24; then r8 @cwp1 reads back p24 value via regs_flat;
//   r31 @cwp3 -> p 8+((48+23) mod 64)=15.
//  r0 write 0xFFFFFFFF -> accepted (wr_ready seen), commit_en==0, p0 stays 0.
//  Back-to-back: 4 writes r9..r12 @cwp1 with data 1..4, valid held high
//   -> wr_ready never drops, p25..p28 == 1..4 in order.
//  Reset mid-stream: push r16=0xA5A5A5A5 then rst on the next edge
//   -> the entry is never committed; all regs 0; busy==0.

Source files
------------

// File: rtl/sparc_rf_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sparc_rf_pkg                                                             |
// | Shared definitions for the SPARC V8 windowed register file: window       |
// | geometry, the logical-to-physical register mapping and the buffered      |
// | write-entry record.                                                      |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package sparc_rf_pkg;

    localparam int unsigned NWINDOWS_DEF = 4;
    localparam int unsigned REG_GLOBALS  = 8;
    localparam int unsigned REGS_PER_WIN = 16;

    // Storage widths of the write-entry record. They are sized for the
    // largest legal configuration (8 windows, 64-bit data); smaller
    // configurations zero-extend into them and ignore the upper bits.
    localparam int unsigned CWP_MAXW  = 3;
    localparam int unsigned DATA_MAXW = 64;

    typedef struct packed {
        logic [4:0]           addr;
        logic [CWP_MAXW-1:0]  cwp;
        logic [DATA_MAXW-1:0] data;
    } wr_entry_t;

    // Logical register (r0-r31) + window pointer -> physical index.
    // Globals map straight through. The 24 windowed registers of window w
    // start at 16*w above the globals, so the ins (r24-r31) of window w
    // land on the outs (r8-r15) of window w+1; the modulo wraps the top
    // window's ins back onto window 0's outs.
    function automatic int unsigned phys_index(input logic [4:0]          addr,
                                               input logic [CWP_MAXW-1:0] cwp,
                                               input int unsigned         nwin);
        int unsigned a;
        int unsigned c;
        a = {27'd0, addr};
        c = {{(32-CWP_MAXW){1'b0}}, cwp};
        if (a < REG_GLOBALS) begin
            return a;
        end
        return REG_GLOBALS + ((c * REGS_PER_WIN + (a - REG_GLOBALS)) % (REGS_PER_WIN * nwin));
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_window_writer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_window_writer_if                                                 |
// | Valid/ready write-request channel into the windowed register file.       |
// |   wr_valid  producer -> rf   write request present                       |
// |   wr_ready  rf -> producer   buffer can accept this cycle                |
// |   wr_addr   producer -> rf   logical register r0-r31                      |
// |   wr_cwp    producer -> rf   window pointer for this write               |
// |   wr_data   producer -> rf   write data                                  |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
interface regfile_window_writer_if #(
    parameter int NWINDOWS = 4,
    parameter int WIDTH    = 32,
    localparam int CWPW    = $clog2(NWINDOWS)
) ();

    logic             wr_valid;
    logic             wr_ready;
    logic [4:0]       wr_addr;
    logic [CWPW-1:0]  wr_cwp;
    logic [WIDTH-1:0] wr_data;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_cwp,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_cwp,
        input  wr_data,
        output wr_ready
    );

endinterface
`default_nettype wire

// File: rtl/rf_phys_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rf_phys_decoder                                                          |
// | Combinational logical-register + CWP -> one-hot physical write enable.   |
// | Demux counterpart of the read-side mux tree. r0 decodes to no enable.    |
// |   i_addr    in   5       logical register r0-r31                         |
// |   i_cwp     in   CWPW    window pointer                                  |
// |   o_onehot  out  NPHYS   one-hot physical enable (all zero for r0)       |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module rf_phys_decoder
    import sparc_rf_pkg::*;
#(
    parameter int NWINDOWS = NWINDOWS_DEF,
    localparam int CWPW    = $clog2(NWINDOWS),
    localparam int NPHYS   = REG_GLOBALS + REGS_PER_WIN * NWINDOWS,
    localparam int PW      = $clog2(NPHYS)
) (
    input  wire logic [4:0]       i_addr,
    input  wire logic [CWPW-1:0]  i_cwp,
    output logic      [NPHYS-1:0] o_onehot
);

    logic [PW-1:0] w_index;
    logic          w_is_r0;

    assign w_index = PW'(phys_index(i_addr, CWP_MAXW'(i_cwp), NWINDOWS));
    // r0 is hardwired zero: the decode still runs, but no enable fires.
    assign w_is_r0 = (i_addr == 5'd0);

    for (genvar p = 0; p < NPHYS; p++) begin : g_onehot
        assign o_onehot[p] = !w_is_r0 && (w_index == PW'(p));
    end

endmodule
`default_nettype wire

// File: rtl/regfile_window_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_window_writer                                                    |
// | Write side of the SPARC V8 windowed register file. Accepts writebacks    |
// | over a valid/ready channel into a 2-entry FIFO, decodes the head entry   |
// | to a one-hot physical enable and commits it to the bank every cycle the  |
// | FIFO holds data. The bank is exported flattened for the read mux tree.   |
// |   clk        in   1            rising-edge clock                        |
// |   rst        in   1            synchronous active-high reset            |
// |   wr         slave            write request channel                    |
// |   busy       out  1            a buffered write is not yet visible      |
// |   commit_en  out  NPHYS        one-hot enable of the committing entry   |
// |   regs_flat  out  NPHYS*WIDTH  physical bank, reg p at [p*WIDTH +: WIDTH]|
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module regfile_window_writer
    import sparc_rf_pkg::*;
#(
    parameter int NWINDOWS = NWINDOWS_DEF,
    parameter int WIDTH    = 32,
    localparam int CWPW    = $clog2(NWINDOWS),
    localparam int NPHYS   = REG_GLOBALS + REGS_PER_WIN * NWINDOWS
) (
    input  wire logic               clk,
    input  wire logic               rst,
    regfile_window_writer_if.slave  wr,
    output logic                    busy,
    output logic [NPHYS-1:0]        commit_en,
    output logic [NPHYS*WIDTH-1:0]  regs_flat
);

    localparam logic [1:0] c_FIFO_DEPTH = 2'd2;

    // ------------------------------------------------------------------
    // Write buffer
    // ------------------------------------------------------------------
    wr_entry_t   r_fifo [2];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;

    wr_entry_t   w_in;
    wr_entry_t   w_head;
    logic        w_full;
    logic        w_push;
    logic        w_pop;

    // Ready depends only on the registered fill level (and reset), never
    // on wr_valid, so the producer sees no combinational loop.
    assign w_full      = (r_count == c_FIFO_DEPTH);
    assign wr.wr_ready = !rst && !w_full;
    assign w_push      = wr.wr_valid && wr.wr_ready;
    // The bank accepts a write every cycle, so a non-empty buffer always
    // drains its head. The second slot exists for a future stall input.
    assign w_pop       = (r_count != 2'd0);
    assign busy        = w_pop;

    always_comb begin
        w_in      = '0;
        w_in.addr = wr.wr_addr;
        w_in.cwp  = CWP_MAXW'(wr.wr_cwp);
        w_in.data = DATA_MAXW'(wr.wr_data);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset: the pointers and count define
    // which slots hold live entries.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_in;
        end
    end

    assign w_head = r_fifo[r_rd_ptr];

    // ------------------------------------------------------------------
    // Decode and commit
    // ------------------------------------------------------------------
    logic [NPHYS-1:0] w_dec_onehot;
    logic [WIDTH-1:0] w_head_data;
    logic             w_unused_head;

    rf_phys_decoder #(
        .NWINDOWS (NWINDOWS)
    ) u_decoder (
        .i_addr   (w_head.addr),
        .i_cwp    (w_head.cwp[CWPW-1:0]),
        .o_onehot (w_dec_onehot)
    );

    assign w_head_data   = w_head.data[WIDTH-1:0];
    // Upper bits of the record are padding in narrower configurations.
    assign w_unused_head = ^{w_head.data, w_head.cwp};

    // Held at zero while in reset so a discarded head never shows an enable.
    assign commit_en = (w_pop && !rst) ? w_dec_onehot : '0;

    // ------------------------------------------------------------------
    // Physical bank. p0 (global r0) is a constant zero, not a register.
    // ------------------------------------------------------------------
    assign regs_flat[0 +: WIDTH] = '0;

    for (genvar p = 1; p < NPHYS; p++) begin : g_bank
        logic [WIDTH-1:0] r_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_q <= '0;
            end else if (commit_en[p]) begin
                r_q <= w_head_data;
            end
        end

        assign regs_flat[p*WIDTH +: WIDTH] = r_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_window_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_regfile_window_writer                                                 |
// | Scoreboard bench: the driver queues the expected commit for every        |
// | accepted write; a monitor pops it when the DUT shows a head entry and    |
// | checks commit_en and the whole bank against a simple array model.        |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_regfile_window_writer;

    localparam int NW = 4;
    localparam int W  = 32;
    localparam int NP = 8 + 16 * NW;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_window_writer_if #(.NWINDOWS(NW), .WIDTH(W)) ifc ();

    logic          busy;
    logic [NP-1:0] commit_en;
    logic [NP*W-1:0] regs_flat;

    regfile_window_writer #(
        .NWINDOWS (NW),
        .WIDTH    (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr        (ifc),
        .busy      (busy),
        .commit_en (commit_en),
        .regs_flat (regs_flat)
    );

    typedef struct {
        int           p;
        logic [W-1:0] data;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] model [NP];
    bit           mon_en = 1'b0;
    int           n_pass = 0;
    int           n_checks = 0;
    int           ready_stalls = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Window view: each window owns 24 consecutive physical registers
    // starting 16*cwp above the globals (outs, locals, ins); anything past
    // the end of the bank wraps around onto window 0's outs.
    function automatic int ref_phys(input int r, input int cwp);
        int p;
        if (r < 8) return r;
        p = 8 + 16 * cwp + (r - 8);
        if (p >= NP) p -= 16 * NW;
        return p;
    endfunction

    function automatic logic [W-1:0] bank_reg(input int p);
        return regs_flat[p*W +: W];
    endfunction

    task automatic clear_model();
        foreach (model[i]) model[i] = '0;
        exp_q.delete();
    endtask

    // Called just after a negedge; returns just after the negedge that
    // follows the accepting edge, with wr_valid dropped.
    task automatic do_write(input int r, input int cwp, input logic [W-1:0] d);
        int   waited;
        exp_t e;
        waited        = 0;
        ifc.wr_valid  = 1'b1;
        ifc.wr_addr   = 5'(r);
        ifc.wr_cwp    = CW'(cwp);
        ifc.wr_data   = d;
        while (!ifc.wr_ready) begin
            if (waited == 20) begin
                n_checks++;
                $display("FAIL wr_ready_timeout: got ready=0 for 20 cycles expected 1");
                ifc.wr_valid = 1'b0;
                return;
            end
            ready_stalls++;
            waited++;
            @(negedge clk);
        end
        @(posedge clk);
        e.p    = ref_phys(r, cwp);
        e.data = d;
        exp_q.push_back(e);
        @(negedge clk);
        ifc.wr_valid = 1'b0;
    endtask

    // Monitor: bank first (reflects commits up to the edge just passed),
    // then the entry committing at the coming edge.
    initial begin : monitor
        int            bad;
        exp_t          e;
        logic [NP-1:0] oh;
        forever begin
            @(negedge clk);
            #1;
            if (mon_en && !rst) begin
                bad = -1;
                for (int p = NP - 1; p >= 0; p--)
                    if (bank_reg(p) !== model[p]) bad = p;
                n_checks++;
                if (bad < 0) n_pass++;
                else $display("FAIL bank p%0d: got %0h expected %0h", bad, bank_reg(bad), model[bad]);
                if (busy) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_commit", commit_en, '0);
                    end else begin
                        e  = exp_q.pop_front();
                        oh = '0;
                        if (e.p != 0) oh[e.p] = 1'b1;
                        chk("commit_en", commit_en, oh);
                        if (e.p != 0) model[e.p] = e.data;
                    end
                end else begin
                    chk("idle_commit_en", commit_en, '0);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        logic [NP-1:0] oh;
        ifc.wr_valid = 1'b0;
        ifc.wr_addr  = '0;
        ifc.wr_cwp   = '0;
        ifc.wr_data  = '0;
        clear_model();

        // Reset held for two edges
        @(negedge clk);
        chk("ready_in_rst_1", ifc.wr_ready, 1'b0);
        @(negedge clk);
        chk("ready_in_rst_2", ifc.wr_ready, 1'b0);
        chk("busy_rst", busy, 1'b0);
        chk("commit_en_rst", commit_en, '0);
        chk("regs_zero_rst", |regs_flat, 1'b0);
        rst    = 1'b0;
        mon_en = 1'b1;
        #1;
        chk("ready_after_rst", ifc.wr_ready, 1'b1);
        @(negedge clk);

        // Single write: enable shows the cycle after acceptance, data after the next edge
        do_write(5, 2, 32'hDEADBEEF);
        oh = '0; oh[5] = 1'b1;
        chk("single_commit_en", commit_en, oh);
        chk("single_p5_not_yet", bank_reg(5), 32'h0);
        @(negedge clk);
        chk("single_p5", bank_reg(5), 32'hDEADBEEF);

        // Window aliasing
        do_write(24, 0, 32'h11111111);
        @(negedge clk);
        chk("alias_p24_ins_w0", bank_reg(24), 32'h11111111);
        do_write(8, 1, 32'h22222222);
        @(negedge clk);
        chk("alias_p24_outs_w1", bank_reg(24), 32'h22222222);
        do_write(31, 3, 32'h33333333);
        @(negedge clk);
        chk("wrap_r31_cwp3_p15", bank_reg(15), 32'h33333333);

        // r0: accepted, occupies a slot, never commits
        chk("r0_ready", ifc.wr_ready, 1'b1);
        do_write(0, 1, 32'hFFFFFFFF);
        chk("r0_busy", busy, 1'b1);
        chk("r0_commit_en", commit_en, '0);
        @(negedge clk);
        chk("r0_p0_zero", bank_reg(0), 32'h0);

        // Back-to-back, valid held high between transfers
        ready_stalls = 0;
        for (int i = 0; i < 4; i++) do_write(9 + i, 1, W'(i + 1));
        chk("b2b_no_stall", ready_stalls, 0);
        @(negedge clk);
        for (int i = 0; i < 4; i++) chk("b2b_data", bank_reg(25 + i), W'(i + 1));

        // Randomized traffic; cwp is scrambled after each transfer
        for (int i = 0; i < 150; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) @(negedge clk);
            do_write($urandom_range(0, 31), $urandom_range(0, NW - 1), W'($urandom));
            ifc.wr_cwp = CW'($urandom_range(0, NW - 1));
        end
        repeat (3) @(negedge clk);
        chk("drain_queue_empty", exp_q.size(), 0);
        chk("drain_busy", busy, 1'b0);

        // Reset on the edge after a push: the entry is dropped, bank cleared
        do_write(16, 0, 32'hA5A5A5A5);
        rst = 1'b1;
        clear_model();
        @(negedge clk);
        chk("ready_mid_rst", ifc.wr_ready, 1'b0);
        @(negedge clk);
        chk("regs_zero_mid_rst", |regs_flat, 1'b0);
        chk("busy_mid_rst", busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("p16_never_committed", bank_reg(16), 32'h0);
        chk("busy_after_rst", busy, 1'b0);
        @(negedge clk);
        chk("regs_zero_after_rst", |regs_flat, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
